frame_stream_tx: RTL

//  Transmit end of the dtype-framed pixel stream consumed by kernel/kernel_with_pipeline.

---
 rtl/frame_stream_tx_pkg.sv | 19 +
 rtl/frame_stream_tx_if.sv | 38 +++
 rtl/frame_stream_tx_header.sv | 50 +++++
 rtl/frame_stream_tx.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_stream_tx_pkg.sv
// Shared word types and constants for the frame stream transmitter.
// Optional header words are enabled by FRAME_STREAM_TX_HEADER_EN.
package frame_stream_tx_pkg;

  localparam int DTYPE_WIDTH = 3;

  typedef logic [DTYPE_WIDTH-1:0] dtype_t;

  localparam dtype_t DTYPE_NONE        = 3'd0;
  localparam dtype_t DTYPE_FRAME_START = 3'd1;
  localparam dtype_t DTYPE_ROW_START   = 3'd2;
  localparam dtype_t DTYPE_PIXEL       = 3'd3;
  localparam dtype_t DTYPE_ROW_END     = 3'd4;
  localparam dtype_t DTYPE_FRAME_END   = 3'd5;
  localparam dtype_t DTYPE_HEADER      = 3'd6;

  localparam int HDR_WORDS = 3;

endpackage

// File: rtl/frame_stream_tx_if.sv
// Pixel FIFO pull side plus framed word output of frame_stream_tx.
// Master is the transmitter; slave is the FIFO/consumer side.
interface frame_stream_tx_if
  import frame_stream_tx_pkg::*;
#(
  parameter int PIXEL_WIDTH = 10,
  parameter int DATA_WIDTH  = 16
) ();

  logic [PIXEL_WIDTH-1:0] pix_datai;
  logic                   pix_empty;
  logic                   pix_re;
  logic                   dvo;
  dtype_t                 dtypeo;
  logic [DATA_WIDTH-1:0]  datao;
  logic [DATA_WIDTH-1:0]  meta_datao;

  modport master (
    input  pix_datai,
    input  pix_empty,
    output pix_re,
    output dvo,
    output dtypeo,
    output datao,
    output meta_datao
  );

  modport slave (
    output pix_datai,
    output pix_empty,
    input  pix_re,
    input  dvo,
    input  dtypeo,
    input  datao,
    input  meta_datao
  );

endinterface

// File: rtl/frame_stream_tx_header.sv
// Header word sequencer: frame_count, num_cols, num_rows.
// Only instantiated when FRAME_STREAM_TX_HEADER_EN is defined.
module frame_stream_tx_header
  import frame_stream_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DIM_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  clear,
  input  logic                  step,
  input  logic [DIM_WIDTH-1:0]  frame_count,
  input  logic [DIM_WIDTH-1:0]  num_cols,
  input  logic [DIM_WIDTH-1:0]  num_rows,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  last
);

  logic [1:0] idx_q, idx_d;

  assign last = (idx_q == 2'(HDR_WORDS - 1));

  always_comb begin
    idx_d = idx_q;
    if (clear) begin
      idx_d = '0;
    end else if (step) begin
      idx_d = last ? 2'd0 : idx_q + 2'd1;
    end
  end

  always_comb begin
    word = '0;
    case (idx_q)
      2'd0:    word = DATA_WIDTH'(frame_count);
      2'd1:    word = DATA_WIDTH'(num_cols);
      default: word = DATA_WIDTH'(num_rows);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/frame_stream_tx.sv
// Framed pixel stream transmitter (FIFO or test pattern source).
// Define FRAME_STREAM_TX_HEADER_EN to emit 3 header words per frame.
module frame_stream_tx
  import frame_stream_tx_pkg::*;
#(
  parameter int PIXEL_WIDTH = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int DIM_WIDTH   = 12,
  parameter int BLANK_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   resetb,
  input  logic                   enable,
  input  logic                   free_run,
  input  logic                   start,
  input  logic                   pattern_en,
  input  logic [DIM_WIDTH-1:0]   num_cols,
  input  logic [DIM_WIDTH-1:0]   num_rows,
  input  logic [BLANK_WIDTH-1:0] hblank,
  input  logic [BLANK_WIDTH-1:0] vblank,
  output logic                   busy,
  frame_stream_tx_if.master      bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FSTART,
    S_HDR,
    S_ROWSTART,
    S_PIX,
    S_ROWEND,
    S_HBLANK,
    S_FEND,
    S_VBLANK
  } state_t;

  localparam logic [DIM_WIDTH-1:0]   DIM_ONE = DIM_WIDTH'(1);
  localparam logic [BLANK_WIDTH-1:0] BLK_ONE = BLANK_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [DIM_WIDTH-1:0]   cols_q, cols_d;
  logic [DIM_WIDTH-1:0]   rows_q, rows_d;
  logic [BLANK_WIDTH-1:0] hbl_q, hbl_d;
  logic [BLANK_WIDTH-1:0] vbl_q, vbl_d;
  logic                   pat_q, pat_d;
  logic [DIM_WIDTH-1:0]   row_q, row_d;
  logic [DIM_WIDTH-1:0]   col_q, col_d;
  logic [DIM_WIDTH-1:0]   frame_q, frame_d;
  logic [BLANK_WIDTH-1:0] blank_q, blank_d;
  logic                   dv_q, dv_d;
  dtype_t                 dtype_q, dtype_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [DATA_WIDTH-1:0]  meta_q, meta_d;
  logic                   busy_q, busy_d;

  logic                   pix_re;
  logic                   launch;
  logic                   row_done;
  logic                   take;
  logic [DIM_WIDTH:0]     rc_sum;
  logic [PIXEL_WIDTH-1:0] pat_pix;

`ifdef FRAME_STREAM_TX_HEADER_EN
  logic                  hdr_step;
  logic                  hdr_last;
  logic [DATA_WIDTH-1:0] hdr_word;

  frame_stream_tx_header #(
    .DATA_WIDTH (DATA_WIDTH),
    .DIM_WIDTH  (DIM_WIDTH)
  ) u_hdr (
    .clk         (clk),
    .resetb      (resetb),
    .clear       (!enable),
    .step        (hdr_step),
    .frame_count (frame_q),
    .num_cols    (cols_q),
    .num_rows    (rows_q),
    .word        (hdr_word),
    .last        (hdr_last)
  );
`endif

  assign rc_sum  = {1'b0, row_q} + {1'b0, col_q};
  assign pat_pix = PIXEL_WIDTH'(rc_sum);
  assign take    = pat_q || !bus.pix_empty;

  always_comb begin
    state_d  = state_q;
    cols_d   = cols_q;
    rows_d   = rows_q;
    hbl_d    = hbl_q;
    vbl_d    = vbl_q;
    pat_d    = pat_q;
    row_d    = row_q;
    col_d    = col_q;
    frame_d  = frame_q;
    blank_d  = blank_q;
    dv_d     = 1'b0;
    dtype_d  = DTYPE_NONE;
    data_d   = '0;
    meta_d   = '0;
    pix_re   = 1'b0;
    launch   = 1'b0;
    row_done = 1'b0;
`ifdef FRAME_STREAM_TX_HEADER_EN
    hdr_step = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        launch = start || free_run;
      end
      S_FSTART: begin
        dv_d    = 1'b1;
        dtype_d = DTYPE_FRAME_START;
        data_d  = DATA_WIDTH'(frame_q);
        row_d   = '0;
`ifdef FRAME_STREAM_TX_HEADER_EN
        state_d = S_HDR;
`else
        state_d = (rows_q == '0) ? S_FEND : S_ROWSTART;
`endif
      end
`ifdef FRAME_STREAM_TX_HEADER_EN
      S_HDR: begin
        dv_d     = 1'b1;
        dtype_d  = DTYPE_HEADER;
        data_d   = hdr_word;
        hdr_step = 1'b1;
        if (hdr_last) begin
          state_d = (rows_q == '0) ? S_FEND : S_ROWSTART;
        end
      end
`endif
      S_ROWSTART: begin
        dv_d    = 1'b1;
        dtype_d = DTYPE_ROW_START;
        data_d  = DATA_WIDTH'(row_q);
        col_d   = '0;
        state_d = (cols_q == '0) ? S_ROWEND : S_PIX;
      end
      S_PIX: begin
        pix_re = !pat_q && !bus.pix_empty;
        if (take) begin
          dv_d    = 1'b1;
          dtype_d = DTYPE_PIXEL;
          data_d  = pat_q ? DATA_WIDTH'(pat_pix)
                          : DATA_WIDTH'(bus.pix_datai);
          meta_d  = DATA_WIDTH'(col_q);
          if (col_q == cols_q - DIM_ONE) begin
            col_d   = '0;
            state_d = S_ROWEND;
          end else begin
            col_d = col_q + DIM_ONE;
          end
        end
      end
      S_ROWEND: begin
        dv_d    = 1'b1;
        dtype_d = DTYPE_ROW_END;
        data_d  = DATA_WIDTH'(row_q);
        if (hbl_q != '0) begin
          blank_d = hbl_q - BLK_ONE;
          state_d = S_HBLANK;
        end else begin
          row_done = 1'b1;
        end
      end
      S_HBLANK: begin
        if (blank_q == '0) begin
          row_done = 1'b1;
        end else begin
          blank_d = blank_q - BLK_ONE;
        end
      end
      S_FEND: begin
        dv_d    = 1'b1;
        dtype_d = DTYPE_FRAME_END;
        data_d  = DATA_WIDTH'(frame_q);
        frame_d = frame_q + DIM_ONE;
        if (vbl_q != '0) begin
          blank_d = vbl_q - BLK_ONE;
          state_d = S_VBLANK;
        end else if (free_run) begin
          launch = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_VBLANK: begin
        if (blank_q != '0) begin
          blank_d = blank_q - BLK_ONE;
        end else if (free_run) begin
          launch = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (row_done) begin
      if (row_q == rows_q - DIM_ONE) begin
        state_d = S_FEND;
      end else begin
        row_d   = row_q + DIM_ONE;
        state_d = S_ROWSTART;
      end
    end

    // Frame geometry is frozen here for the whole frame.
    if (launch) begin
      state_d = S_FSTART;
      cols_d  = num_cols;
      rows_d  = num_rows;
      hbl_d   = hblank;
      vbl_d   = vblank;
      pat_d   = pattern_en;
      row_d   = '0;
      col_d   = '0;
    end

    // Never pop the FIFO into a frame that is being aborted.
    if (!enable) begin
      state_d = S_IDLE;
      row_d   = '0;
      col_d   = '0;
      frame_d = '0;
      blank_d = '0;
      dv_d    = 1'b0;
      dtype_d = DTYPE_NONE;
      data_d  = '0;
      meta_d  = '0;
      pix_re  = 1'b0;
`ifdef FRAME_STREAM_TX_HEADER_EN
      hdr_step = 1'b0;
`endif
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q <= S_IDLE;
      cols_q  <= '0;
      rows_q  <= '0;
      hbl_q   <= '0;
      vbl_q   <= '0;
      pat_q   <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      frame_q <= '0;
      blank_q <= '0;
      dv_q    <= 1'b0;
      dtype_q <= DTYPE_NONE;
      data_q  <= '0;
      meta_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cols_q  <= cols_d;
      rows_q  <= rows_d;
      hbl_q   <= hbl_d;
      vbl_q   <= vbl_d;
      pat_q   <= pat_d;
      row_q   <= row_d;
      col_q   <= col_d;
      frame_q <= frame_d;
      blank_q <= blank_d;
      dv_q    <= dv_d;
      dtype_q <= dtype_d;
      data_q  <= data_d;
      meta_q  <= meta_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.pix_re     = pix_re;
  assign bus.dvo        = dv_q;
  assign bus.dtypeo     = dtype_q;
  assign bus.datao      = data_q;
  assign bus.meta_datao = meta_q;
  assign busy           = busy_q;

endmodule
